// File: rtl/led_fade_driver_if.sv
// LED fade driver signal bundle: on/off requests and enable in, PWM pins, levels and busy out.
// The slave modport is the driver itself; the master modport is whatever produces the requests.
interface led_fade_driver_if #(
  parameter int NUM_LEDS = 4,
  parameter int PWM_BITS = 8
);
  logic [NUM_LEDS-1:0]          led_req;
  logic                         enable;
  logic [NUM_LEDS-1:0]          led_pwm;
  logic [NUM_LEDS*PWM_BITS-1:0] level_bus;
  logic                         busy;

  modport master (output led_req, enable, input led_pwm, level_bus, busy);
  modport slave  (input led_req, enable, output led_pwm, level_bus, busy);
endinterface

// File: rtl/led_fade_driver.sv
// Per-LED PWM driver with linear fade between off and full brightness.
// Brightness moves one step per prescaler tick toward the requested target.
module led_fade_driver #(
  parameter int NUM_LEDS   = 4,
  parameter int PWM_BITS   = 8,
  parameter int FADE_DIV   = 256,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  led_fade_driver_if.slave  io
);

  localparam int PS_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(FADE_DIV - 1);
  localparam logic PIN_OFF = (ACTIVE_LOW != 0);

  logic [PS_W-1:0]                    presc_q, presc_d;
  logic [PWM_BITS-1:0]                pwm_cnt_q, pwm_cnt_d;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0]  level_q, level_d;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0]  target;
  logic [NUM_LEDS-1:0]                led_pwm_q, led_pwm_d;
  logic                               tick;

  // One step toward the target; equality holds, so 0 and MAX never wrap.
  function automatic logic [PWM_BITS-1:0] step_level(input logic [PWM_BITS-1:0] lvl,
                                                     input logic [PWM_BITS-1:0] tgt);
    if (lvl < tgt)      return lvl + PWM_BITS'(1);
    else if (lvl > tgt) return lvl - PWM_BITS'(1);
    else                return lvl;
  endfunction

  function automatic logic pwm_on(input logic [PWM_BITS-1:0] lvl,
                                  input logic [PWM_BITS-1:0] cnt);
    return (lvl == MAX) || (lvl > cnt);
  endfunction

  always_comb begin
    tick      = (presc_q == PS_LAST);
    presc_d   = tick ? '0 : presc_q + PS_W'(1);
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    target    = '0;
    level_d   = level_q;
    led_pwm_d = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      target[i] = (io.enable && io.led_req[i]) ? MAX : '0;
      if (tick) level_d[i] = step_level(level_q[i], target[i]);
      led_pwm_d[i] = pwm_on(level_q[i], pwm_cnt_q) ^ PIN_OFF;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      level_q   <= '0;
      led_pwm_q <= {NUM_LEDS{PIN_OFF}};
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      level_q   <= level_d;
      led_pwm_q <= led_pwm_d;
    end
  end

  always_comb begin
    io.busy = 1'b0;
    for (int i = 0; i < NUM_LEDS; i++)
      if (level_q[i] != target[i]) io.busy = 1'b1;
  end

  assign io.led_pwm   = led_pwm_q;
  assign io.level_bus = level_q;

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver at PWM_BITS=4: a main FADE_DIV=2 instance,
// an inverted-pin copy, and a slow FADE_DIV=64 copy used to observe a steady duty cycle.
module tb_led_fade_driver;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  led_fade_driver_if #(.NUM_LEDS(4), .PWM_BITS(4)) ifc1 ();
  led_fade_driver_if #(.NUM_LEDS(4), .PWM_BITS(4)) ifc2 ();
  led_fade_driver_if #(.NUM_LEDS(4), .PWM_BITS(4)) ifc3 ();

  assign ifc2.led_req = ifc1.led_req;
  assign ifc2.enable  = ifc1.enable;
  assign ifc3.led_req = ifc1.led_req;
  assign ifc3.enable  = ifc1.enable;

  led_fade_driver #(.NUM_LEDS(4), .PWM_BITS(4), .FADE_DIV(2), .ACTIVE_LOW(0))
    dut (.clk(clk), .reset_n(reset_n), .io(ifc1.slave));
  led_fade_driver #(.NUM_LEDS(4), .PWM_BITS(4), .FADE_DIV(2), .ACTIVE_LOW(1))
    dut_inv (.clk(clk), .reset_n(reset_n), .io(ifc2.slave));
  led_fade_driver #(.NUM_LEDS(4), .PWM_BITS(4), .FADE_DIV(64), .ACTIVE_LOW(0))
    dut_slow (.clk(clk), .reset_n(reset_n), .io(ifc3.slave));

  typedef struct {
    int          adv;
    logic [3:0]  req;
    logic        en;
    logic [15:0] lvl;
    logic        bsy;
  } vec_t;

  vec_t fade_tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] req, input logic en);
    @(negedge clk);
    reset_n = 1'b0;
    ifc1.led_req = req;
    ifc1.enable  = en;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lvl;
    int highs;
    logic exp_on;

    fade_tbl[0] = '{1,  4'b0001, 1'b1, 16'h0000, 1'b1};
    fade_tbl[1] = '{1,  4'b0001, 1'b1, 16'h0001, 1'b1};
    fade_tbl[2] = '{2,  4'b0001, 1'b1, 16'h0002, 1'b1};
    fade_tbl[3] = '{10, 4'b0001, 1'b1, 16'h0007, 1'b1};
    fade_tbl[4] = '{4,  4'b0001, 1'b1, 16'h0009, 1'b1};
    fade_tbl[5] = '{11, 4'b0001, 1'b1, 16'h000E, 1'b1};
    fade_tbl[6] = '{1,  4'b0001, 1'b1, 16'h000F, 1'b0};
    fade_tbl[7] = '{1,  4'b0001, 1'b1, 16'h000F, 1'b0};

    ifc1.led_req = 4'b0000;
    ifc1.enable  = 1'b1;

    // Idle: nothing requested stays dark forever.
    do_reset(4'b0000, 1'b1);
    #1;
    chk("rst_level", ifc1.level_bus, 16'h0000);
    chk("rst_pwm", ifc1.led_pwm, 4'b0000);
    chk("rst_busy", ifc1.busy, 1'b0);
    chk("rst_pwm_inv", ifc2.led_pwm, 4'b1111);
    for (int e = 1; e <= 40; e++) begin
      adv(1);
      chk("idle_pwm", ifc1.led_pwm, 4'b0000);
    end
    chk("idle_level", ifc1.level_bus, 16'h0000);
    chk("idle_busy", ifc1.busy, 1'b0);
    chk("idle_pwm_inv", ifc2.led_pwm, 4'b1111);

    // Fade-in of LED0, table driven.
    do_reset(4'b0001, 1'b1);
    for (int v = 0; v < 8; v++) begin
      ifc1.led_req = fade_tbl[v].req;
      ifc1.enable  = fade_tbl[v].en;
      adv(fade_tbl[v].adv);
      chk($sformatf("fade_level[%0d]", v), ifc1.level_bus, fade_tbl[v].lvl);
      chk($sformatf("fade_busy[%0d]", v), ifc1.busy, fade_tbl[v].bsy);
    end
    for (int e = 0; e < 32; e++) begin
      adv(1);
      chk("full_on_pwm", ifc1.led_pwm, 4'b0001);
    end
    chk("full_on_pwm_inv", ifc2.led_pwm, 4'b1110);

    // Reversal of LED1 at level 9.
    do_reset(4'b0010, 1'b1);
    adv(18);
    chk("rev_peak", ifc1.level_bus, 16'h0090);
    ifc1.led_req = 4'b0000;
    for (int e = 19; e <= 40; e++) begin
      adv(1);
      lvl = (e < 20) ? 9 : (((e - 20) / 2 >= 8) ? 0 : 8 - (e - 20) / 2);
      chk($sformatf("rev_level@%0d", e), ifc1.level_bus, 32'(lvl) << 4);
      chk($sformatf("rev_busy@%0d", e), ifc1.busy, 32'(lvl != 0));
    end
    for (int e = 41; e <= 60; e++) begin
      adv(1);
      chk("rev_pwm_off", ifc1.led_pwm, 4'b0000);
    end

    // Global disable from full brightness on all four.
    do_reset(4'b1111, 1'b1);
    adv(30);
    chk("all_full", ifc1.level_bus, 16'hFFFF);
    chk("all_full_busy", ifc1.busy, 1'b0);
    ifc1.enable = 1'b0;
    #1;
    chk("dis_busy_comb", ifc1.busy, 1'b1);
    for (int e = 31; e <= 62; e++) begin
      adv(1);
      lvl = (e < 32) ? 15 : (((e - 30) / 2 >= 15) ? 0 : 15 - (e - 30) / 2);
      chk($sformatf("dis_level@%0d", e), ifc1.level_bus, {4{4'(lvl)}});
      chk($sformatf("dis_busy@%0d", e), ifc1.busy, 32'(lvl != 0));
      if (e == 31) begin
        chk("dis_pwm_full", ifc1.led_pwm, 4'b1111);
        chk("dis_pwm_full_inv", ifc2.led_pwm, 4'b0000);
      end
    end

    // A request pulse confined to a non-tick edge is ignored.
    do_reset(4'b0000, 1'b1);
    adv(2);
    ifc1.led_req = 4'b0001;
    #1;
    chk("pulse_busy", ifc1.busy, 1'b1);
    adv(1);
    ifc1.led_req = 4'b0000;
    adv(3);
    chk("pulse_level", ifc1.level_bus, 16'h0000);
    chk("pulse_busy_after", ifc1.busy, 1'b0);

    // Enable drop and request rise together leave the target at 0.
    ifc1.led_req = 4'b1111;
    ifc1.enable  = 1'b0;
    #1;
    chk("drop_rise_busy", ifc1.busy, 1'b0);
    adv(4);
    chk("drop_rise_level", ifc1.level_bus, 16'h0000);

    // Asynchronous reset in the middle of a fade.
    do_reset(4'b1111, 1'b1);
    adv(14);
    chk("mid_level", ifc1.level_bus, 16'h7777);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_level", ifc1.level_bus, 16'h0000);
    chk("async_pwm", ifc1.led_pwm, 4'b0000);
    chk("async_pwm_inv", ifc2.led_pwm, 4'b1111);
    chk("async_busy", ifc1.busy, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    adv(1);
    chk("restart_edge1", ifc1.level_bus, 16'h0000);
    adv(1);
    chk("restart_edge2", ifc1.level_bus, 16'h1111);

    // Steady duty at level 4 on the slow instance.
    do_reset(4'b0001, 1'b1);
    adv(256);
    chk("duty_level", ifc3.level_bus, 16'h0004);
    highs = 0;
    for (int e = 257; e <= 320; e++) begin
      adv(1);
      exp_on = ((e - 1) % 16) < 4;
      chk($sformatf("duty_pwm@%0d", e), ifc3.led_pwm, {3'b000, exp_on});
      if (ifc3.led_pwm[0]) highs++;
    end
    chk("duty_high_count", highs, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
